// File: rtl/load_wb_stage.sv
// Load-result formatting plus a 2-entry write-back FIFO that feeds the register-file write port.
// Optional forwarding of queued results is enabled with LOAD_WB_BYPASS_EN.
module load_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [RD_W-1:0]   in_rd_addr_i,
    input  logic              in_rd_wena_i,
    input  logic              in_is_load_i,
    input  logic [2:0]        in_funct3_i,
    input  logic [1:0]        in_addr_low_i,
    input  logic [DATA_W-1:0] in_alu_data_i,
    input  logic [DATA_W-1:0] in_mem_data_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [RD_W-1:0]   wb_rd_addr_o,
    output logic              wb_wena_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              load_fault_o
`ifdef LOAD_WB_BYPASS_EN
   ,output logic              byp_valid_o,
    output logic [RD_W-1:0]   byp_rd_addr_o,
    output logic [DATA_W-1:0] byp_data_o
`endif
);

    typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StFull = 2'd2} fifo_state_e;

    fifo_state_e       state_q;
    logic [DATA_W-1:0] data_q [2];
    logic [RD_W-1:0]   rd_q   [2];
    logic [1:0]        wena_q;
    logic              wr_ptr_q, rd_ptr_q;
    logic              load_fault_q;

    logic              accept, pop, fault;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] fmt_data;

    // Ready comes only from registered state so wb_ready_i never reaches in_ready_o.
    assign in_ready_o = (state_q != StFull);
    assign wb_valid_o = (state_q != StEmpty);
    assign accept     = in_valid_i & in_ready_o;
    assign pop        = wb_valid_o & wb_ready_i;

    always_comb begin
        byte_sel = in_mem_data_i[7:0];
        case (in_addr_low_i)
            2'd1:    byte_sel = in_mem_data_i[15:8];
            2'd2:    byte_sel = in_mem_data_i[23:16];
            2'd3:    byte_sel = in_mem_data_i[31:24];
            default: byte_sel = in_mem_data_i[7:0];
        endcase
        half_sel = in_addr_low_i[1] ? in_mem_data_i[31:16] : in_mem_data_i[15:0];
        fault    = 1'b0;
        fmt_data = '0;
        if (!in_is_load_i) begin
            fmt_data = in_alu_data_i;
        end else begin
            case (in_funct3_i)
                3'b000: fmt_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
                3'b001: begin
                    if (in_addr_low_i[0]) fault = 1'b1;
                    else fmt_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
                end
                3'b010: begin
                    if (in_addr_low_i != 2'd0) fault = 1'b1;
                    else fmt_data = in_mem_data_i;
                end
                3'b100: fmt_data = {{(DATA_W-8){1'b0}}, byte_sel};
                3'b101: begin
                    if (in_addr_low_i[0]) fault = 1'b1;
                    else fmt_data = {{(DATA_W-16){1'b0}}, half_sel};
                end
                default: fault = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StEmpty;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            data_q[0]    <= '0;
            data_q[1]    <= '0;
            rd_q[0]      <= '0;
            rd_q[1]      <= '0;
            wena_q       <= '0;
            load_fault_q <= 1'b0;
        end else begin
            load_fault_q <= accept & fault;
            if (accept) begin
                data_q[wr_ptr_q] <= fmt_data;
                rd_q[wr_ptr_q]   <= in_rd_addr_i;
                // x0 is hard-wired, and faulting loads must not disturb the register file.
                wena_q[wr_ptr_q] <= in_rd_wena_i & (in_rd_addr_i != '0) & ~fault;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case (state_q)
                StEmpty: if (accept) state_q <= StOne;
                StOne: begin
                    if (accept && !pop)      state_q <= StFull;
                    else if (!accept && pop) state_q <= StEmpty;
                end
                StFull:  if (pop) state_q <= StOne;
                default: state_q <= StEmpty;
            endcase
        end
    end

    assign wb_rd_addr_o = rd_q[rd_ptr_q];
    assign wb_wena_o    = wena_q[rd_ptr_q];
    assign wb_data_o    = data_q[rd_ptr_q];
    assign load_fault_o = load_fault_q;

`ifdef LOAD_WB_BYPASS_EN
    // Slot behind the write pointer is the newest entry; with one entry it is also the head.
    always_comb begin
        byp_valid_o   = 1'b0;
        byp_rd_addr_o = '0;
        byp_data_o    = '0;
        if (state_q != StEmpty) begin
            if (wena_q[~wr_ptr_q]) begin
                byp_valid_o   = 1'b1;
                byp_rd_addr_o = rd_q[~wr_ptr_q];
                byp_data_o    = data_q[~wr_ptr_q];
            end else if (wena_q[rd_ptr_q]) begin
                byp_valid_o   = 1'b1;
                byp_rd_addr_o = rd_q[rd_ptr_q];
                byp_data_o    = data_q[rd_ptr_q];
            end
        end
    end
`endif

endmodule

// File: tb/tb_load_wb_stage.sv
// Scoreboard bench for load_wb_stage: randomized and directed traffic against a behavioural model.
// Define LOAD_WB_BYPASS_EN to also exercise the bypass ports.
module tb_load_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i, in_ready_o, in_rd_wena_i, in_is_load_i;
    logic [4:0]  in_rd_addr_i;
    logic [2:0]  in_funct3_i;
    logic [1:0]  in_addr_low_i;
    logic [31:0] in_alu_data_i, in_mem_data_i;
    logic        wb_valid_o, wb_ready_i, wb_wena_o, load_fault_o;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_data_o;
`ifdef LOAD_WB_BYPASS_EN
    logic        byp_valid_o;
    logic [4:0]  byp_rd_addr_o;
    logic [31:0] byp_data_o;
`endif

    always #5 clk = ~clk;

    load_wb_stage #(.DATA_W(32), .RD_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_rd_addr_i(in_rd_addr_i), .in_rd_wena_i(in_rd_wena_i),
        .in_is_load_i(in_is_load_i), .in_funct3_i(in_funct3_i),
        .in_addr_low_i(in_addr_low_i), .in_alu_data_i(in_alu_data_i),
        .in_mem_data_i(in_mem_data_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rd_addr_o(wb_rd_addr_o), .wb_wena_o(wb_wena_o), .wb_data_o(wb_data_o),
        .load_fault_o(load_fault_o)
`ifdef LOAD_WB_BYPASS_EN
       ,.byp_valid_o(byp_valid_o), .byp_rd_addr_o(byp_rd_addr_o), .byp_data_o(byp_data_o)
`endif
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic        wena;
        logic [31:0] data;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   model_cnt = 0;
    bit   fault_prev = 1'b0;
    ent_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural formatting rules, written with plain arithmetic on the memory word.
    function automatic void ref_model(input logic [4:0] rd, input bit we, input bit ld,
                                      input logic [2:0] f3, input logic [1:0] a,
                                      input logic [31:0] alu, input logic [31:0] mem,
                                      output ent_t e, output bit bad);
        longint v;
        longint m;
        m   = longint'(mem);
        v   = 0;
        bad = 1'b0;
        if (!ld) v = longint'(alu);
        else begin
            case (f3)
                3'd0: begin v = (m >> (8 * a)) % 256; if (v >= 128) v = v - 256; end
                3'd1: if (a % 2 != 0) bad = 1'b1;
                      else begin v = (m >> (8 * a)) % 65536; if (v >= 32768) v = v - 65536; end
                3'd2: if (a != 0) bad = 1'b1; else v = m;
                3'd4: v = (m >> (8 * a)) % 256;
                3'd5: if (a % 2 != 0) bad = 1'b1; else v = (m >> (8 * a)) % 65536;
                default: bad = 1'b1;
            endcase
        end
        e.rd   = rd;
        e.data = bad ? 32'd0 : v[31:0];
        e.wena = we && (rd != 5'd0) && !bad;
    endfunction

    // Monitor: every DUT pop is checked against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && wb_valid_o && wb_ready_i) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_underflow: got an output with no expected entry (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check("wb_rd_addr", 64'(wb_rd_addr_o), 64'(mon_e.rd));
                check("wb_wena", 64'(wb_wena_o), 64'(mon_e.wena));
                check("wb_data", 64'(wb_data_o), 64'(mon_e.data));
            end
        end
    end

    // One cycle of stimulus; expectation pushed when the model says the transfer happens.
    task automatic step(input bit v, input logic [4:0] rd, input bit we, input bit ld,
                        input logic [2:0] f3, input logic [1:0] a, input logic [31:0] alu,
                        input logic [31:0] mem, input bit rdy, output bit acc);
        ent_t e;
        bit   bad;
        bit   pop;
        @(posedge clk);
        #1;
        in_valid_i = v; in_rd_addr_i = rd; in_rd_wena_i = we; in_is_load_i = ld;
        in_funct3_i = f3; in_addr_low_i = a; in_alu_data_i = alu; in_mem_data_i = mem;
        wb_ready_i = rdy;
        @(negedge clk);
        check("in_ready", 64'(in_ready_o), 64'(model_cnt != 2));
        check("wb_valid", 64'(wb_valid_o), 64'(model_cnt != 0));
        check("load_fault", 64'(load_fault_o), 64'(fault_prev));
        acc = v && (model_cnt != 2);
        pop = rdy && (model_cnt != 0);
        ref_model(rd, we, ld, f3, a, alu, mem, e, bad);
        if (acc) sb.push_back(e);
        fault_prev = acc && bad;
        model_cnt = model_cnt + int'(acc) - int'(pop);
    endtask

    task automatic idle(input bit rdy);
        bit acc;
        step(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0, rdy, acc);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_wb_wena", 64'(wb_wena_o), 64'd0);
        check("rst_wb_rd", 64'(wb_rd_addr_o), 64'd0);
        check("rst_wb_data", 64'(wb_data_o), 64'd0);
        check("rst_fault", 64'(load_fault_o), 64'd0);
`ifdef LOAD_WB_BYPASS_EN
        check("rst_byp_valid", 64'(byp_valid_o), 64'd0);
`endif
        sb.delete();
        model_cnt  = 0;
        fault_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        int tries;
        rst = 1'b1;
        in_valid_i = 0; in_rd_addr_i = 0; in_rd_wena_i = 0; in_is_load_i = 0;
        in_funct3_i = 0; in_addr_low_i = 0; in_alu_data_i = 0; in_mem_data_i = 0;
        wb_ready_i = 0;
        #12;
        rst = 1'b0;
        do_reset();

        // LB / LBU from byte lane 2
        step(1, 5'd4, 1, 1, 3'b000, 2'd2, 32'd0, 32'h1280_3456, 0, acc);
        idle(0);
        check("lb_data", 64'(wb_data_o), 64'hFFFF_FF80);
        check("lb_wena", 64'(wb_wena_o), 64'd1);
        idle(1);
        step(1, 5'd4, 1, 1, 3'b100, 2'd2, 32'd0, 32'h1280_3456, 0, acc);
        idle(0);
        check("lbu_data", 64'(wb_data_o), 64'h0000_0080);
        idle(1);

        // Misaligned LH faults, then an aligned LW
        step(1, 5'd5, 1, 1, 3'b001, 2'd1, 32'd0, 32'h1234_5678, 0, acc);
        idle(0);
        check("lh_mis_wena", 64'(wb_wena_o), 64'd0);
        check("lh_mis_data", 64'(wb_data_o), 64'd0);
        check("lh_mis_fault", 64'(load_fault_o), 64'd1);
        idle(1);
        check("fault_one_cycle", 64'(load_fault_o), 64'd0);
        step(1, 5'd6, 1, 1, 3'b010, 2'd0, 32'd0, 32'hDEAD_BEEF, 0, acc);
        idle(0);
        check("lw_data", 64'(wb_data_o), 64'hDEAD_BEEF);
        idle(1);

        // Back-pressure: third result must wait until the write port drains
        step(1, 5'd1, 1, 0, 3'd0, 2'd0, 32'd1, 32'd0, 0, acc);
        step(1, 5'd2, 1, 0, 3'd0, 2'd0, 32'd2, 32'd0, 0, acc);
        step(1, 5'd3, 1, 0, 3'd0, 2'd0, 32'd3, 32'd0, 0, acc);
        check("full_not_ready", 64'(in_ready_o), 64'd0);
        acc = 0;
        tries = 0;
        while (!acc && tries < 10) begin
            step(1, 5'd3, 1, 0, 3'd0, 2'd0, 32'd3, 32'd0, 1, acc);
            tries++;
        end
        check("third_accepted", 64'(acc), 64'd1);
        repeat (3) idle(1);

        // Streaming with a ready write port
        for (int i = 0; i < 20; i++)
            step(1, 5'(i + 1), 1, 0, 3'd0, 2'd0, 32'(i * 7 + 100), 32'd0, 1, acc);
        idle(1);
        idle(1);

        // Write to x0 is suppressed
        step(1, 5'd0, 1, 0, 3'd0, 2'd0, 32'hCAFE_0000, 32'd0, 0, acc);
        idle(0);
        check("x0_wena", 64'(wb_wena_o), 64'd0);
        idle(1);

`ifdef LOAD_WB_BYPASS_EN
        step(1, 5'd3, 1, 0, 3'd0, 2'd0, 32'h0000_0033, 32'd0, 0, acc);
        step(1, 5'd7, 1, 0, 3'd0, 2'd0, 32'h0000_0077, 32'd0, 0, acc);
        idle(0);
        check("byp_valid", 64'(byp_valid_o), 64'd1);
        check("byp_rd", 64'(byp_rd_addr_o), 64'd7);
        check("byp_data", 64'(byp_data_o), 64'h77);
        repeat (3) idle(1);
`endif

        // Reset while full discards in-flight entries
        step(1, 5'd9, 1, 0, 3'd0, 2'd0, 32'd9, 32'd0, 0, acc);
        step(1, 5'd10, 1, 0, 3'd0, 2'd0, 32'd10, 32'd0, 0, acc);
        idle(0);
        do_reset();
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 $urandom, $urandom, ($urandom_range(0, 9) < 6), acc);
        end

        repeat (4) idle(1);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
